calc_sequencer: RTL

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_sequencer.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/calc_sequencer.sv
// ---------------------------------------------------------------------------
// calc_sequencer
//
// Keypad front end for a two-operand add/subtract calculator. It turns scanned
// key levels into clean one-cycle key events, builds up to three-digit decimal
// operands, asks an external ALU to add or subtract them, and chooses what the
// display shows.
//
// Configuration macro: KEY_DEBOUNCE_EN
//   defined   : a press is accepted after DEBOUNCE_CYCLES stable high cycles,
//               and the block re-arms after DEBOUNCE_CYCLES low cycles.
//   undefined : a press is accepted on the first high cycle after a low cycle,
//               and the block re-arms after one low cycle (DEBOUNCE_CYCLES unused).
//
// Ports
//   clk         in   system clock (rising edge)
//   rst         in   synchronous active-high reset
//   key_valid   in   key-down level from the matrix scanner
//   key_value   in   [3:0] key code: 0-9 digit, 10 ADD, 11 SUB, 12 EQUALS, 13 CLEAR
//   alu_done    in   one-cycle ALU completion pulse
//   alu_result  in   [9:0] signed ALU result, valid with alu_done
//   op_a, op_b  out  [7:0] unsigned operands
//   op_sel      out  0 = add, 1 = subtract
//   alu_start   out  one-cycle operation request
//   key_strobe  out  one-cycle pulse per accepted key
//   key_code    out  [3:0] code of the accepted key
//   display     out  [9:0] signed value to show
//   state       out  [1:0] ENTER_A=0, ENTER_B=1, WAIT_ALU=2, SHOW=3
// ---------------------------------------------------------------------------
module calc_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_value,
  input  logic       alu_done,
  input  logic [9:0] alu_result,
  output logic [7:0] op_a,
  output logic [7:0] op_b,
  output logic       op_sel,
  output logic       alu_start,
  output logic       key_strobe,
  output logic [3:0] key_code,
  output logic [9:0] display,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_ENTER_A  = 2'd0,
    ST_ENTER_B  = 2'd1,
    ST_WAIT_ALU = 2'd2,
    ST_SHOW     = 2'd3
  } state_e;

  localparam logic [3:0] KEY_ADD    = 4'd10;
  localparam logic [3:0] KEY_SUB    = 4'd11;
  localparam logic [3:0] KEY_EQUALS = 4'd12;
  localparam logic [3:0] KEY_CLEAR  = 4'd13;

  // -------------------------------------------------------------------------
  // Key acceptance
  // -------------------------------------------------------------------------
  logic armed_q, armed_d;
  logic accept;

`ifdef KEY_DEBOUNCE_EN
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  // cnt_q counts stable cycles already seen: high cycles with the same code
  // while armed, low cycles while disarmed. Zero while armed means no
  // candidate code is being tracked yet.
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] last_q, last_d;

  // NOTE: every combinational output gets a default first, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    accept  = 1'b0;
    armed_d = armed_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (armed_q) begin
      if (!key_valid) begin
        cnt_d = 8'd0;
      end else if (cnt_q != 8'd0 && key_value == last_q) begin
        if (cnt_q == CNT_LAST) begin
          accept  = 1'b1;
          armed_d = 1'b0;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end else begin
        // First high cycle, or the code changed: restart the stable count.
        cnt_d  = 8'd1;
        last_d = key_value;
      end
    end else begin
      if (key_valid) begin
        cnt_d = 8'd0;
      end else if (cnt_q == CNT_LAST) begin
        armed_d = 1'b1;
        cnt_d   = 8'd0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q <= 1'b1;
      cnt_q   <= 8'd0;
      last_q  <= 4'd0;
    end else begin
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end
`else
  // Plain edge detection: armed means key_valid was low last cycle (or we
  // just left reset).
  always_comb begin
    accept  = armed_q & key_valid;
    armed_d = ~key_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) armed_q <= 1'b1;
    else     armed_q <= armed_d;
  end

  logic unused_debounce_cfg;
  assign unused_debounce_cfg = ^8'(DEBOUNCE_CYCLES);
`endif

  logic       key_strobe_q;
  logic [3:0] key_code_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_strobe_q <= 1'b0;
      key_code_q   <= 4'd0;
    end else begin
      key_strobe_q <= accept;
      if (accept) key_code_q <= key_value;
    end
  end

  // -------------------------------------------------------------------------
  // Calculator FSM, acting on the registered key event
  // -------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [7:0] op_a_q, op_a_d;
  logic [7:0] op_b_q, op_b_d;
  logic       op_sel_q, op_sel_d;
  logic [1:0] ndig_q, ndig_d;    // digits accepted into the current operand
  logic [9:0] result_q, result_d;
  logic       alu_start_q, alu_start_d;

  logic        is_digit, is_op, is_clear;
  logic [7:0]  entry_base;
  logic [11:0] entry_val;
  logic        entry_ok;

  assign is_digit   = key_code_q <= 4'd9;
  assign is_op      = key_code_q == KEY_ADD || key_code_q == KEY_SUB;
  assign is_clear   = key_code_q == KEY_CLEAR;
  assign entry_base = (state_q == ST_ENTER_B) ? op_b_q : op_a_q;
  assign entry_val  = {4'd0, entry_base} * 12'd10 + {8'd0, key_code_q};
  assign entry_ok   = ndig_q != 2'd3 && entry_val <= 12'd255;

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_sel_d    = op_sel_q;
    ndig_d      = ndig_q;
    result_d    = result_q;
    alu_start_d = 1'b0;

    unique case (state_q)
      ST_ENTER_A: begin
        if (key_strobe_q) begin
          if (is_digit) begin
            if (entry_ok) begin
              op_a_d = entry_val[7:0];
              ndig_d = ndig_q + 2'd1;
            end
          end else if (is_op) begin
            op_sel_d = key_code_q == KEY_SUB;
            op_b_d   = 8'd0;
            ndig_d   = 2'd0;
            state_d  = ST_ENTER_B;
          end else if (is_clear) begin
            op_a_d   = 8'd0;
            op_b_d   = 8'd0;
            op_sel_d = 1'b0;
            ndig_d   = 2'd0;
          end
        end
      end
      ST_ENTER_B: begin
        if (key_strobe_q) begin
          if (is_digit) begin
            if (entry_ok) begin
              op_b_d = entry_val[7:0];
              ndig_d = ndig_q + 2'd1;
            end
          end else if (is_op) begin
            op_sel_d = key_code_q == KEY_SUB;
          end else if (key_code_q == KEY_EQUALS) begin
            alu_start_d = 1'b1;
            state_d     = ST_WAIT_ALU;
          end else if (is_clear) begin
            op_a_d   = 8'd0;
            op_b_d   = 8'd0;
            op_sel_d = 1'b0;
            ndig_d   = 2'd0;
            state_d  = ST_ENTER_A;
          end
        end
      end
      ST_WAIT_ALU: begin
        // Keys are swallowed here so the operands stay stable for the ALU.
        if (alu_done) begin
          result_d = alu_result;
          state_d  = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (key_strobe_q) begin
          if (is_digit) begin
            op_a_d  = {4'd0, key_code_q};
            op_b_d  = 8'd0;
            ndig_d  = 2'd1;
            state_d = ST_ENTER_A;
          end else if (is_clear) begin
            op_a_d   = 8'd0;
            op_b_d   = 8'd0;
            op_sel_d = 1'b0;
            ndig_d   = 2'd0;
            state_d  = ST_ENTER_A;
          end
        end
      end
      default: state_d = ST_ENTER_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ENTER_A;
      op_a_q      <= 8'd0;
      op_b_q      <= 8'd0;
      op_sel_q    <= 1'b0;
      ndig_q      <= 2'd0;
      result_q    <= 10'd0;
      alu_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_sel_q    <= op_sel_d;
      ndig_q      <= ndig_d;
      result_q    <= result_d;
      alu_start_q <= alu_start_d;
    end
  end

  always_comb begin
    unique case (state_q)
      ST_ENTER_A: display = {2'd0, op_a_q};
      ST_SHOW:    display = result_q;
      default:    display = {2'd0, op_b_q};
    endcase
  end

  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign op_sel     = op_sel_q;
  assign alu_start  = alu_start_q;
  assign key_strobe = key_strobe_q;
  assign key_code   = key_code_q;
  assign state      = state_q;

endmodule
